// File: rtl/gf180mcu_fd_sc_mcu9t5v0__andn_pipe.sv
// gf180mcu_fd_sc_mcu9t5v0__andn_pipe
//
// Pipelined multi-channel AND reduction. Each channel reduces WIDTH input bits
// to one bit through a registered tree of 3-input AND groups. An optional
// frame-accumulate mode ANDs per-beat results across a frame and emits one
// bit per frame.
//
// Pipeline: input register -> LEVELS tree stages -> output register, so a
// beat accepted at edge n shows up with Z_VALID=1 after edge n+LEVELS+1.
//
// Ports:
//   CLK       sole clock, rising edge
//   RST       asynchronous active-high reset
//   A         CHANNELS*WIDTH input bits, channel c at [c*WIDTH +: WIDTH]
//   A_VALID   input beat present
//   A_LAST    beat closes a frame (accumulate mode only)
//   ACC_MODE  0 = per-beat result, 1 = frame accumulate (tagged per beat)
//   A_READY   block accepts a beat this cycle
//   Z         reduction result, bit c for channel c
//   Z_VALID   Z holds a result
//   Z_READY   downstream accepts Z

module gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] A,
    input  logic                      A_VALID,
    input  logic                      A_LAST,
    input  logic                      ACC_MODE,
    output logic                      A_READY,
    output logic [CHANNELS-1:0]       Z,
    output logic                      Z_VALID,
    input  logic                      Z_READY
);

    // Number of 3-input AND levels: max(1, ceil(log3(w))).
    function automatic int tree_levels(input int w);
        int l;
        int p;
        l = 0;
        p = 1;
        while (p < w) begin
            p = p * 3;
            l = l + 1;
        end
        if (l < 1) l = 1;
        return l;
    endfunction

    function automatic int pow3(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 3;
        return r;
    endfunction

    localparam int LEVELS = tree_levels(WIDTH);
    localparam int PADDED = pow3(LEVELS);

    // Every stage advances together; a stalled output freezes the whole pipe.
    logic en;
    assign en      = !Z_VALID || Z_READY;
    assign A_READY = en;

    logic [CHANNELS*WIDTH-1:0]  in_data;
    logic [LEVELS:0]            stage_valid;
    logic [LEVELS:0]            stage_mode;
    logic [LEVELS:0]            stage_last;
    logic [CHANNELS*PADDED-1:0] padded_in;
    logic [CHANNELS-1:0]        tree_result;
    logic [CHANNELS-1:0]        acc;

    // Input register plus the valid/mode/last tag shift chain. Index 0 is the
    // input register, index k is tree level k. Bubbles shift along unchanged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_data     <= '0;
            stage_valid <= '0;
            stage_mode  <= '0;
            stage_last  <= '0;
        end else if (en) begin
            in_data     <= A;
            stage_valid <= {stage_valid[LEVELS-1:0], A_VALID};
            stage_mode  <= {stage_mode[LEVELS-1:0], ACC_MODE};
            stage_last  <= {stage_last[LEVELS-1:0], A_LAST};
        end
    end

    // Widen each channel to a full power of three; missing inputs read as 1
    // so they never affect the AND.
    always_comb begin
        padded_in = '1;
        for (int c = 0; c < CHANNELS; c++) begin
            padded_in[c*PADDED +: WIDTH] = in_data[c*WIDTH +: WIDTH];
        end
    end

    // Tree level k holds CHANNELS*3^(LEVELS-k) bits; channel c's groups sit
    // contiguously, so group g always reads source bits [3g +: 3] and channels
    // never mix.
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int OUT_W = pow3(LEVELS - k);

        logic [CHANNELS*3*OUT_W-1:0] src;
        logic [CHANNELS*OUT_W-1:0]   grp_and;
        logic [CHANNELS*OUT_W-1:0]   data;

        if (k == 1) begin : g_first
            assign src = padded_in;
        end else begin : g_next
            assign src = g_lvl[k-1].data;
        end

        always_comb begin
            grp_and = '0;
            for (int g = 0; g < CHANNELS*OUT_W; g++) begin
                grp_and[g] = &src[3*g +: 3];
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                data <= '0;
            end else if (en) begin
                data <= grp_and;
            end
        end
    end

    assign tree_result = g_lvl[LEVELS].data;

    // Output stage. Per-beat results go straight to Z and discard any partial
    // frame; accumulate beats fold into acc and only the last one emits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Z       <= '0;
            Z_VALID <= 1'b0;
            acc     <= '1;
        end else if (en) begin
            if (stage_valid[LEVELS]) begin
                if (!stage_mode[LEVELS]) begin
                    Z       <= tree_result;
                    Z_VALID <= 1'b1;
                    acc     <= '1;
                end else if (!stage_last[LEVELS]) begin
                    acc     <= acc & tree_result;
                    Z_VALID <= 1'b0;
                end else begin
                    Z       <= acc & tree_result;
                    Z_VALID <= 1'b1;
                    acc     <= '1;
                end
            end else begin
                Z_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe
//
// Scoreboard bench for the pipelined AND reduction. Three instances are
// exercised: WIDTH=9 (LEVELS=2), WIDTH=10 (LEVELS=3) and WIDTH=1 (LEVELS=1),
// all with CHANNELS=2. Index d selects the instance: 0=w9, 1=w10, 2=w1.

module tb_gf180mcu_fd_sc_mcu9t5v0__andn_pipe;

    typedef struct {
        logic [1:0] z;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  a_valid;
    logic [2:0]  a_last;
    logic [2:0]  acc_mode;
    logic [2:0]  z_ready;
    wire  [2:0]  a_ready;
    wire  [2:0]  z_valid;
    logic [17:0] a_w9;
    logic [19:0] a_w10;
    logic [1:0]  a_w1;
    wire  [1:0]  z_w9;
    wire  [1:0]  z_w10;
    wire  [1:0]  z_w1;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    // Edge counter: after edge k has happened, cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(9), .CHANNELS(2)) dut_w9 (
        .CLK(clk), .RST(rst[0]), .A(a_w9), .A_VALID(a_valid[0]),
        .A_LAST(a_last[0]), .ACC_MODE(acc_mode[0]), .A_READY(a_ready[0]),
        .Z(z_w9), .Z_VALID(z_valid[0]), .Z_READY(z_ready[0])
    );

    gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(10), .CHANNELS(2)) dut_w10 (
        .CLK(clk), .RST(rst[1]), .A(a_w10), .A_VALID(a_valid[1]),
        .A_LAST(a_last[1]), .ACC_MODE(acc_mode[1]), .A_READY(a_ready[1]),
        .Z(z_w10), .Z_VALID(z_valid[1]), .Z_READY(z_ready[1])
    );

    gf180mcu_fd_sc_mcu9t5v0__andn_pipe #(.WIDTH(1), .CHANNELS(2)) dut_w1 (
        .CLK(clk), .RST(rst[2]), .A(a_w1), .A_VALID(a_valid[2]),
        .A_LAST(a_last[2]), .ACC_MODE(acc_mode[2]), .A_READY(a_ready[2]),
        .Z(z_w1), .Z_VALID(z_valid[2]), .Z_READY(z_ready[2])
    );

    function automatic string dut_name(input int d);
        if (d == 0) return "w9";
        if (d == 1) return "w10";
        return "w1";
    endfunction

    // Tree depth per instance, derived by hand from max(1, ceil(log3(WIDTH))).
    function automatic int latency_of(input int d);
        if (d == 0) return 2;
        if (d == 1) return 3;
        return 1;
    endfunction

    function automatic logic [1:0] get_z(input int d);
        if (d == 0) return z_w9;
        if (d == 1) return z_w10;
        return z_w1;
    endfunction

    function automatic int qsize(input int d);
        if (d == 0) return sb0.size();
        if (d == 1) return sb1.size();
        return sb2.size();
    endfunction

    function automatic logic [19:0] mk9(input logic [8:0] ch1, input logic [8:0] ch0);
        return {2'b00, ch1, ch0};
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int d, output exp_t e);
        case (d)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
    endtask

    task automatic qclear(input int d);
        case (d)
            0:       sb0.delete();
            1:       sb1.delete();
            default: sb2.delete();
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every handshaken output is matched against the head of the
    // instance's scoreboard queue, including its arrival edge when timed.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (z_valid[d] && z_ready[d] && !rst[d]) begin
                if (qsize(d) == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL %s unexpected output: got z=%0b, expected none (t=%0t)",
                             dut_name(d), get_z(d), $time);
                end else begin
                    exp_t e;
                    qpop(d, e);
                    checkOutput({dut_name(d), " z"}, 32'(get_z(d)), 32'(e.z));
                    if (e.cyc >= 0) checkOutput({dut_name(d), " arrival edge"}, cyc, e.cyc);
                end
            end
        end
    end

    // Offers one beat (starting just after a rising edge) and holds it until
    // accepted; on acceptance optionally pushes the expected result.
    task automatic applyStimulus(input int d, input logic [19:0] data, input logic m,
                                 input logic last, input logic push, input logic [1:0] ez,
                                 input logic timed);
        int   tries;
        exp_t e;
        tries = 0;
        case (d)
            0:       a_w9  = data[17:0];
            1:       a_w10 = data;
            default: a_w1  = data[1:0];
        endcase
        a_valid[d]  = 1'b1;
        acc_mode[d] = m;
        a_last[d]   = last;
        @(negedge clk);
        while (!a_ready[d] && tries < 50) begin
            tries++;
            @(negedge clk);
        end
        if (!a_ready[d]) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s accept timeout: got a_ready=0, expected 1 within 50 cycles", dut_name(d));
            @(posedge clk);
            #1;
            a_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        a_valid[d] = 1'b0;
        if (push) begin
            e.z   = ez;
            e.cyc = timed ? cyc + latency_of(d) + 1 : -1;
            qpush(d, e);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int d);
        int t;
        t = 0;
        while (qsize(d) != 0 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (qsize(d) != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s drain timeout: got %0d pending, expected 0", dut_name(d), qsize(d));
            qclear(d);
        end
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without a clock.
    task automatic resetPulse(input int d, input string tag);
        #1;
        rst[d] = 1'b1;
        #1;
        checkOutput({dut_name(d), " ", tag, " z_valid"}, 32'(z_valid[d]), 32'd0);
        checkOutput({dut_name(d), " ", tag, " z"}, 32'(get_z(d)), 32'd0);
        checkOutput({dut_name(d), " ", tag, " a_ready"}, 32'(a_ready[d]), 32'd1);
        qclear(d);
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    task automatic resetScenario(input int d);
        // Mid-frame: acc holds zeros when reset hits, so it must be restored.
        applyStimulus(d, 20'h00000, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        waitCycles(latency_of(d) + 3);
        resetPulse(d, "midframe");
        applyStimulus(d, 20'hFFFFF, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1);
        waitDrain(d);
        // Mid-stall: one result parked on Z, another in flight.
        applyStimulus(d, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        applyStimulus(d, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        z_ready[d] = 1'b0;
        waitCycles(latency_of(d) + 3);
        checkOutput({dut_name(d), " stalled z_valid"}, 32'(z_valid[d]), 32'd1);
        resetPulse(d, "midstall");
        z_ready[d] = 1'b1;
        applyStimulus(d, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        waitDrain(d);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 3'b111;
        a_valid  = 3'b000;
        a_last   = 3'b000;
        acc_mode = 3'b000;
        z_ready  = 3'b111;
        a_w9     = '0;
        a_w10    = '0;
        a_w1     = '0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput({dut_name(d), " reset z_valid"}, 32'(z_valid[d]), 32'd0);
            checkOutput({dut_name(d), " reset z"}, 32'(get_z(d)), 32'd0);
            checkOutput({dut_name(d), " reset a_ready"}, 32'(a_ready[d]), 32'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 3'b000;

        // First beat: nothing visible until LEVELS+1 edges after acceptance.
        $display("[TB] first beat latency");
        applyStimulus(0, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("w9 pre-latency z_valid", 32'(z_valid[0]), 32'd0);
            checkOutput("w9 pre-latency z", 32'(z_w9), 32'd0);
        end
        @(posedge clk);
        #1;
        waitDrain(0);

        // Per-beat streaming on consecutive cycles.
        $display("[TB] per-beat streaming");
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        applyStimulus(0, mk9(9'h1FF, 9'h1EF), 1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        waitDrain(0);

        // Backpressure: four beats in flight, five stalled edges.
        $display("[TB] backpressure");
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
        applyStimulus(0, mk9(9'h1FF, 9'h1EF), 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
        applyStimulus(0, mk9(9'h1FE, 9'h1FF), 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        applyStimulus(0, mk9(9'h0FF, 9'h17F), 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
        z_ready[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("w9 stall a_ready", 32'(a_ready[0]), 32'd0);
            checkOutput("w9 stall z_valid", 32'(z_valid[0]), 32'd1);
            checkOutput("w9 stall z hold", 32'(z_w9), 32'b11);
        end
        @(posedge clk);
        #1;
        z_ready[0] = 1'b1;
        waitDrain(0);

        // Accumulate: ch1 bit 0 low only in the middle beat.
        $display("[TB] accumulate frame");
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(0, mk9(9'h1FE, 9'h1FF), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b1, 1'b1, 1'b1, 2'b01, 1'b1);
        waitDrain(0);
        waitCycles(4);

        // Mode change mid-frame discards the partial frame.
        $display("[TB] mode change mid-frame");
        applyStimulus(0, mk9(9'h1FF, 9'h000), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
        applyStimulus(0, mk9(9'h1FF, 9'h1FF), 1'b1, 1'b1, 1'b1, 2'b11, 1'b1);
        waitDrain(0);

        // Asynchronous reset mid-frame and mid-stall on every width.
        for (int d = 0; d < 3; d++) begin
            $display("[TB] reset scenario %s", dut_name(d));
            resetScenario(d);
        end

        waitCycles(6);
        for (int d = 0; d < 3; d++) begin
            checkOutput({dut_name(d), " leftover expectations"}, qsize(d), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
